// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

  // E-stage forwarding mux selects
  localparam logic [1:0] FWD_NONE = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_M    = 2'b01;  // operand from M-stage result
  localparam logic [1:0] FWD_W    = 2'b10;  // operand from W-stage result

  // Divide hold timer states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/pipeline_ctrl_div_stall_timer.sv
// Holds the E stage for DIV_CYCLES cycles while a div/divu occupies it.
// Latency: div_busy rises combinationally in the launch cycle; it stays high for DIV_CYCLES cycles in total.
// Backpressure: waits in DONE until E advances (stallE low), so the same divide is never relaunched.
// Ports: clk, resetn (async, active-low); div_reqE (E holds a divide, level), start_ok (launch allowed),
//        stallE (E is held this cycle), abort (kill any divide in flight); div_busy (hold E, flush M).
module div_stall_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic div_reqE,
  input  logic start_ok,
  input  logic stallE,
  input  logic abort,
  output logic div_busy
);

  localparam int CW = $clog2(DIV_CYCLES);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic             launch;

  // The launch cycle counts as the first held cycle, so RUN covers the remaining DIV_CYCLES-1.
  assign launch   = (state_q == DIV_IDLE) && div_reqE && start_ok;
  assign div_busy = launch || (state_q == DIV_RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else if (abort) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (launch) begin
            cnt_q   <= CW'(DIV_CYCLES - 1);
            state_q <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          // Keeps counting through memory stalls: the divider runs regardless.
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          if (!stallE) state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage hazard unit: forwarding selects, load-use/branch interlocks, and per-stage stall/flush
// control merging memory stalls, multi-cycle divide, precise M exceptions and E mispredicts.
// Latency: forwarding/stall/flush are combinational; flushes raised during a memory stall are
// latched and applied in the first cycle after release. Backpressure: a memory stall freezes
// every stage and suppresses all flushes.
// Ports: clk, resetn (async, active-low); D/E/M/W register addresses and write enables;
//        div_reqE, i_stall, d_stall, exceptionM, mispredictE; forward*, stall*, flush*,
//        longest_stall, div_busy, timeout (sticky until reset).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int TO_LIMIT   = 1023
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  input  logic              div_reqE,
  input  logic              i_stall,
  input  logic              d_stall,
  input  logic              exceptionM,
  input  logic              mispredictE,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              longest_stall,
  output logic              div_busy,
  output logic              timeout
);

  localparam int SCW = $clog2(TO_LIMIT + 1);

  logic           lwstall, brstall, haz;
  logic           exc, mis;
  logic           pend_exc_q, pend_exc_d;
  logic           pend_mis_q, pend_mis_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           timeout_q;

  // ---------------- forwarding ----------------
  assign forwardaD = (rsD != '0) && regwriteM && (writeregM == rsD);
  assign forwardbD = (rtD != '0) && regwriteM && (writeregM == rtD);

  // M has the younger result, so it wins over W.
  always_comb begin
    forwardaE = FWD_NONE;
    if ((rsE != '0) && regwriteM && (writeregM == rsE))      forwardaE = FWD_M;
    else if ((rsE != '0) && regwriteW && (writeregW == rsE)) forwardaE = FWD_W;
    forwardbE = FWD_NONE;
    if ((rtE != '0) && regwriteM && (writeregM == rtE))      forwardbE = FWD_M;
    else if ((rtE != '0) && regwriteW && (writeregW == rtE)) forwardbE = FWD_W;
  end

  // ---------------- interlocks ----------------
  assign lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign brstall = branchD &&
                   ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                    (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  assign haz     = lwstall || brstall;

  assign longest_stall = i_stall || d_stall;

  // Pending requests replay the flush that a memory stall deferred.
  assign exc = exceptionM || pend_exc_q;
  assign mis = (mispredictE || pend_mis_q) && !exc;

  // ---------------- divide timer ----------------
  div_stall_timer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .div_reqE (div_reqE),
    .start_ok (!longest_stall && !exc),
    .stallE   (stallE),
    .abort    (exc),
    .div_busy (div_busy)
  );

  // ---------------- stall / flush ----------------
  always_comb begin
    stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1; stallW = 1'b1;
    flushF = 1'b0; flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
    if (!longest_stall) begin
      flushF = exc;
      flushD = exc || mis;
      flushE = exc || (haz && !mis);
      // Bubble into M while E is held by the divider.
      flushM = exc || div_busy;
      stallF = (haz || div_busy) && !exc && !mis;
      stallD = stallF;
      stallE = div_busy && !exc;
      stallM = 1'b0;
      stallW = 1'b0;
    end
  end

  // ---------------- pending flushes and stall watchdog ----------------
  always_comb begin
    pend_exc_d = longest_stall && (pend_exc_q || exceptionM);
    // An exception kills everything younger, so a mispredict seen alongside it is dropped.
    pend_mis_d = longest_stall && (pend_mis_q || mispredictE) && !exc;
    stall_cnt_d = '0;
    if (longest_stall)
      stall_cnt_d = (stall_cnt_q == SCW'(TO_LIMIT)) ? stall_cnt_q : stall_cnt_q + SCW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_exc_q  <= 1'b0;
      pend_mis_q  <= 1'b0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      pend_exc_q  <= pend_exc_d;
      pend_mis_q  <= pend_mis_d;
      stall_cnt_q <= stall_cnt_d;
      // Asserts in the cycle the counter reaches TO_LIMIT.
      if (stall_cnt_d == SCW'(TO_LIMIT)) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with DIV_CYCLES=4, TO_LIMIT=8.
// Inputs are driven at the falling edge and outputs sampled 2 time units later (before the rising edge).
module tb_pipeline_ctrl;

  logic       clk;
  logic       resetn;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW;
  logic       div_reqE, i_stall, d_stall, exceptionM, mispredictE;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushF, flushD, flushE, flushM, flushW;
  logic       longest_stall, div_busy, timeout;

  logic [4:0] stall_v, flush_v;
  assign stall_v = {stallF, stallD, stallE, stallM, stallW};
  assign flush_v = {flushF, flushD, flushE, flushM, flushW};

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_ctrl #(
    .REG_AW(5), .DIV_CYCLES(4), .TO_LIMIT(8)
  ) dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .div_reqE(div_reqE), .i_stall(i_stall), .d_stall(d_stall),
    .exceptionM(exceptionM), .mispredictE(mispredictE),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .longest_stall(longest_stall), .div_busy(div_busy), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    branchD = 0; regwriteE = 0; memtoregE = 0; regwriteM = 0; memtoregM = 0; regwriteW = 0;
    div_reqE = 0; i_stall = 0; d_stall = 0; exceptionM = 0; mispredictE = 0;
  endtask

  initial begin
    resetn = 1'b1;
    clr();
    #1 resetn = 1'b0;
    #1;
    // reset state
    chk("rst_stall", 32'(stall_v), 0);
    chk("rst_flush", 32'(flush_v), 0);
    chk("rst_fwd", 32'({forwardaD, forwardbD, forwardaE, forwardbE}), 0);
    chk("rst_misc", 32'({longest_stall, div_busy, timeout}), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // forwarding
    @(negedge clk); clr();
    rsE = 3; regwriteM = 1; writeregM = 3; regwriteW = 1; writeregW = 3;
    #2 chk("fwdaE_M_beats_W", 32'(forwardaE), 1);
    rsE = 0;
    #2 chk("fwdaE_r0", 32'(forwardaE), 0);
    @(negedge clk);
    regwriteM = 0; rsE = 3; rtE = 3;
    #2 chk("fwdaE_W", 32'(forwardaE), 2);
    chk("fwdbE_W", 32'(forwardbE), 2);
    @(negedge clk); clr();
    regwriteM = 1; writeregM = 3; rsD = 3; rtD = 2;
    #2 chk("fwdD", 32'({forwardaD, forwardbD}), 2);

    // load-use interlock, then with mispredict
    @(negedge clk); clr();
    memtoregE = 1; rtE = 5; rsD = 5;
    #2 chk("lw_stall", 32'(stall_v), 5'b11000);
    chk("lw_flush", 32'(flush_v), 5'b00100);
    mispredictE = 1;
    #1 chk("lw_mis_stall", 32'(stall_v), 0);
    chk("lw_mis_flush", 32'(flush_v), 5'b01000);

    // branch interlocks (E ALU result, M load)
    @(negedge clk); clr();
    branchD = 1; rtD = 4; regwriteE = 1; writeregE = 4;
    #2 chk("br_E_stall", 32'(stall_v), 5'b11000);
    chk("br_E_flush", 32'(flush_v), 5'b00100);
    @(negedge clk); clr();
    branchD = 1; rsD = 6; memtoregM = 1; writeregM = 6;
    #2 chk("br_M_stall", 32'(stall_v), 5'b11000);

    // divide: 4 held cycles then DONE with request still high
    @(negedge clk); clr();
    div_reqE = 1;
    #2 chk("div_c1_busy", 32'(div_busy), 1);
    chk("div_c1_stall", 32'(stall_v), 5'b11100);
    chk("div_c1_flush", 32'(flush_v), 5'b00010);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      #2 chk($sformatf("div_c%0d_busy", c), 32'(div_busy), 1);
    end
    @(negedge clk);
    #2 chk("div_done_busy", 32'(div_busy), 0);
    chk("div_done_stall", 32'(stall_v), 0);
    chk("div_done_flush", 32'(flush_v), 0);
    @(negedge clk); div_reqE = 0;
    #2 chk("div_after_busy", 32'(div_busy), 0);

    // exception aborts divide in cycle 2
    @(negedge clk); clr();
    div_reqE = 1;
    #2 chk("dexc_c1_busy", 32'(div_busy), 1);
    @(negedge clk); exceptionM = 1;
    #2 chk("dexc_flush", 32'(flush_v), 5'b11110);
    chk("dexc_stall", 32'(stall_v), 0);
    @(negedge clk); clr();
    #2 chk("dexc_next_busy", 32'(div_busy), 0);
    chk("dexc_next_flush", 32'(flush_v), 0);

    // mispredict during 3-cycle data stall is deferred to release
    @(negedge clk); clr();
    d_stall = 1;
    #2 chk("ds_c1_stall", 32'(stall_v), 5'b11111);
    chk("ds_c1_flush", 32'(flush_v), 0);
    chk("ds_c1_long", 32'(longest_stall), 1);
    @(negedge clk); mispredictE = 1;
    #2 chk("ds_c2_flush", 32'(flush_v), 0);
    @(negedge clk); mispredictE = 0;
    #2 chk("ds_c3_flush", 32'(flush_v), 0);
    @(negedge clk); d_stall = 0;
    #2 chk("ds_rel_flush", 32'(flush_v), 5'b01000);
    chk("ds_rel_stall", 32'(stall_v), 0);
    @(negedge clk);
    #2 chk("ds_after_flush", 32'(flush_v), 0);

    // exception + mispredict together during a stall: exception replayed on release
    @(negedge clk); clr();
    i_stall = 1; exceptionM = 1; mispredictE = 1;
    #2 chk("xs_hold_flush", 32'(flush_v), 0);
    @(negedge clk); clr();
    #2 chk("xs_rel_flush", 32'(flush_v), 5'b11110);
    @(negedge clk);
    #2 chk("xs_after_flush", 32'(flush_v), 0);

    // divide cannot launch during a memory stall; launches on release
    @(negedge clk); clr();
    d_stall = 1; div_reqE = 1;
    #2 chk("dstall_nolaunch", 32'(div_busy), 0);
    @(negedge clk); d_stall = 0;
    #2 chk("dstall_launch", 32'(div_busy), 1);
    repeat (4) @(negedge clk);
    clr();
    #2 chk("dstall_idle", 32'(div_busy), 0);

    // timeout after 8 consecutive stall cycles, sticky
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); clr(); i_stall = 1;
      #2;
      if (k == 8) chk("to_c8", 32'(timeout), 0);
      if (k == 9) chk("to_c9", 32'(timeout), 1);
    end
    @(negedge clk); clr();
    #2 chk("to_sticky", 32'(timeout), 1);
    chk("to_long_off", 32'(longest_stall), 0);

    // asynchronous reset in the middle of a divide
    @(negedge clk); div_reqE = 1;
    #2 chk("ar_launch", 32'(div_busy), 1);
    @(negedge clk); div_reqE = 0;
    #1 chk("ar_run", 32'(div_busy), 1);
    resetn = 1'b0;
    #1 chk("ar_busy", 32'(div_busy), 0);
    chk("ar_timeout", 32'(timeout), 0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    #2 chk("ar_after", 32'({div_busy, timeout}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
